// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder and its storage bank.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEPTH_WORDS = 64;
    localparam int DMEM_WAIT_CYCLES = 2;
    localparam int DMEM_CNT_W       = 4;

    // Byte-enable i covers data bits [8i+7:8i].
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage: synchronous byte-lane write, combinational read, contents survive reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] w_mask;

    assign w_mask = be_to_mask(i_be);

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable wait states and address checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);

    dmem_state_e           r_state, w_state_nxt;
    logic [DMEM_CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_err;
    logic          w_bank_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_bank_rdata;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept = req_valid && (r_state == IDLE);

    // With zero wait states RESP is entered on the acceptance edge itself, so the
    // commit path must see the live request rather than the capture registers.
    assign w_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_be    = (r_state == IDLE) ? req_be    : r_be;

    assign w_err = (w_addr[1:0] != 2'b00) || (|(w_addr >> (AW + 2)));
    assign w_idx = w_addr[AW+1:2];

    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
    // The bank has no reset, so gate on reset to keep a held request from writing.
    assign w_bank_we    = w_enter_resp && w_we && !w_err && reset;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (!w_we && !w_err) ? w_bank_rdata : 32'h0;
            end
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_bank_we),
        .i_be    (w_be),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_bank_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench: default build plus a zero-wait build, both against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WC    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = 4'hF;
    logic        z_rsp_ready;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;
    assign z_rsp_ready = 1'b1;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] mem_m [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
            1:       return $urandom_range(DEPTH, 1023) * 4;
            2:       return $urandom;
            default: return $urandom_range(0, DEPTH - 1) * 4;
        endcase
    endfunction

    // One complete request/response on the default build, checked against mem_m.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold);
        int lat;
        logic e_err;
        logic [31:0] e_rd;
        e_err = addr_bad(addr);
        e_rd  = 32'h0;
        if (!we && !e_err) e_rd = mem_m[addr / 4];
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++; $display("FAIL idle_ready got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk); #1;
        if (we && !e_err) mem_m[addr / 4] = merge(mem_m[addr / 4], wd, be);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            req_valid = 1'($urandom); req_we = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        compared++;
        if (lat != WC + 1) begin
            mismatched++; $display("FAIL latency addr=%h got %0d want %0d", addr, lat, WC + 1);
        end
        compared++;
        if ({rsp_err, rsp_rdata} !== {e_err, e_rd}) begin
            mismatched++;
            $display("FAIL response addr=%h we=%b got err=%b rdata=%h want err=%b rdata=%h",
                     addr, we, rsp_err, rsp_rdata, e_err, e_rd);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = $urandom;
            @(posedge clk); #1;
            compared++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, e_err, e_rd}) begin
                mismatched++;
                $display("FAIL hold_stable cyc=%0d got v=%b rdy=%b err=%b rd=%h want v=1 rdy=0 err=%b rd=%h",
                         h, rsp_valid, req_ready, rsp_err, rsp_rdata, e_err, e_rd);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        compared++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL release got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        compared++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            mismatched++;
            $display("FAIL %s got rdy=%b v=%b err=%b rd=%h want rdy=1 v=0 err=0 rd=0",
                     name, req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_a");
        compared++;
        if ({z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            mismatched++;
            $display("FAIL reset_b got rdy=%b v=%b err=%b rd=%h want 1 0 0 0",
                     z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    endtask

    task automatic test_directed();
        xact(1'b1, 32'h64, 32'h0000_0019, 4'hF, 0);
        xact(1'b0, 32'h64, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h10, 32'hAABB_CCDD, 4'hF, 0);
        xact(1'b1, 32'h10, 32'h0011_0000, 4'b0100, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 0);
        xact(1'b0, 32'h14, 32'h0, 4'h0, 0);
        xact(1'b0, 32'h66, 32'h0, 4'h0, 0);
        xact(1'b0, 32'h100, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h100, 32'h1234_5678, 4'hF, 0);
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0);
        xact(1'b0, 32'hFC, 32'h0, 4'h0, 0);
    endtask

    task automatic test_backpressure();
        xact(1'b0, 32'h10, 32'h0, 4'h0, 5);
        xact(1'b1, 32'h24, $urandom, 4'($urandom), 5);
        xact(1'b0, 32'h24, 32'h0, 4'h0, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++)
            xact(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3));
    endtask

    task automatic test_reset_midflight();
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = ~mem_m[8]; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_in_wait");
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = ~mem_m[8]; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #4;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset_at_resp_entry");
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0);
    endtask

    task automatic test_zero_wait();
        logic [31:0] q_addr [12];
        logic        q_we   [12];
        logic [31:0] q_wd   [12];
        logic [31:0] zmem   [4];
        logic        rdy, e_err;
        logic [31:0] e_rd;
        int k, prev;
        for (int i = 0; i < 12; i++) begin
            q_we[i]   = (i < 4);
            q_addr[i] = (i < 4) ? 32'(i * 4) : 32'($urandom_range(0, 3) * 4);
            q_wd[i]   = $urandom;
        end
        q_addr[9] = 32'h11;
        k = 0; prev = -1;
        for (int e = 0; e < 40 && k < 12; e++) begin
            @(negedge clk);
            rdy = z_req_ready;
            z_req_valid = 1'b1; z_req_we = q_we[k]; z_req_addr = q_addr[k]; z_req_wdata = q_wd[k];
            @(posedge clk); #1;
            if (rdy) begin
                e_err = addr_bad(q_addr[k]);
                e_rd  = 32'h0;
                if (!q_we[k] && !e_err) e_rd = zmem[q_addr[k] / 4];
                if (q_we[k] && !e_err) zmem[q_addr[k] / 4] = q_wd[k];
                compared++;
                if ({z_rsp_valid, z_rsp_err, z_rsp_rdata} !== {1'b1, e_err, e_rd}) begin
                    mismatched++;
                    $display("FAIL zw_resp k=%0d got v=%b err=%b rd=%h want v=1 err=%b rd=%h",
                             k, z_rsp_valid, z_rsp_err, z_rsp_rdata, e_err, e_rd);
                end
                if (prev >= 0) begin
                    compared++;
                    if (e - prev != 2) begin
                        mismatched++; $display("FAIL zw_spacing got %0d want 2", e - prev);
                    end
                end
                prev = e;
                k++;
            end else begin
                compared++;
                if (z_rsp_valid !== 1'b0) begin
                    mismatched++; $display("FAIL zw_bubble got v=%b want 0", z_rsp_valid);
                end
            end
        end
        z_req_valid = 1'b0;
        compared++;
        if (k != 12) begin
            mismatched++; $display("FAIL zw_count got %0d want 12", k);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
